acumulador_paridad_serie: RTL and testbench
===========================================

Name: acumulador_paridad_serie

Overview:
Serial parity accumulator that sits directly upstream of the two-input XOR stage. Each cycle it feeds that stage the pair {running parity, incoming bit} and registers the result. After ANCHO_TRAMA accepted bits it presents the frame parity on a valid/ready output. It is the sequential companion of the combinational XOR and is used to build parity generators and checkers for serial links.

Parameters:
ANCHO_TRAMA, 8, number of data bits per frame; legal range 1..255.
PARIDAD_IMPAR, 0, 0 = even parity (Salida = XOR of frame bits); 1 = odd parity (Salida = inverted XOR).

Ports:
Reloj  input  1  single clock; all state changes on the rising edge.
Reset  input  1  asynchronous, active-high reset.
Entrada  input  1  serial data bit.
EntradaValida  input  1  Entrada carries a valid bit this cycle.
EntradaLista  output  1  block accepts a bit this cycle.
Abortar  input  1  synchronous frame discard.
Salida  output  1  frame parity; valid only while SalidaValida = 1.
SalidaValida  output  1  Salida holds a completed frame parity.
SalidaLista  input  1  consumer accepts Salida this cycle.
Contador  output  $clog2(ANCHO_TRAMA+1)  bits accepted in the current frame.
Ocupado  output  1  high when the state is not REPOSO.

Behaviour:
- Reset is asynchronous, active-high, and takes effect immediately without waiting for a clock edge.
  - While Reset = 1: state REPOSO, parity register P = 0, Contador = 0, Salida = 0, SalidaValida = 0, Ocupado = 0, EntradaLista = 0.
  - On release: EntradaLista = 1 at the first edge-free evaluation; no waiting cycle is required.
- Input handshake: a bit is accepted on a rising edge where EntradaValida = 1 and EntradaLista = 1. Nothing else changes P or Contador.
- EntradaLista = 1 in REPOSO and ACUMULA, 0 in ENTREGA. It is a pure decode of the state.
- Accumulation:
  - First accepted bit of a frame: P <= Entrada.
  - Each later bit: P <= P XOR Entrada, i.e. the XOR of the 2-bit vector {P, Entrada}.
  - Contador increments by 1 per accepted bit and never exceeds ANCHO_TRAMA.
- State machine:
  - REPOSO: on accept, go to ACUMULA with Contador = 1. If ANCHO_TRAMA = 1, go directly to ENTREGA instead.
  - ACUMULA: on each accept, Contador++. When the accept makes Contador = ANCHO_TRAMA, go to ENTREGA.
  - ENTREGA: SalidaValida = 1 and Salida = P XOR PARIDAD_IMPAR. Both hold stable until SalidaLista = 1. On that edge go to REPOSO, Contador = 0, P = 0, SalidaValida = 0.
- Latency: SalidaValida rises on the edge that accepts the final bit and is visible the cycle after that bit was presented. The minimum frame period is ANCHO_TRAMA + 1 cycles. The output-handshake cycle accepts no input; the next frame's first bit can be accepted in the following cycle.
- Salida = 0 whenever SalidaValida = 0.
- Abortar (synchronous) in any state, on the next edge: return to REPOSO, P = 0, Contador = 0, SalidaValida = 0.
  - Abortar has priority over an input accept and an output handshake in the same cycle; the bit or the parity is discarded.
- EntradaValida while in ENTREGA: ignored (EntradaLista = 0). The upstream source must hold its bit.
- SalidaLista while not in ENTREGA: ignored.
- Ocupado = 1 in ACUMULA and ENTREGA.

Test Plan:
1. ANCHO_TRAMA=8, PARIDAD_IMPAR=0; release reset; stream 1,0,1,1,0,0,1,0 back-to-back with SalidaLista=1 -> Contador counts 1..8; SalidaValida=1 for one cycle after the 8th bit with Salida=0; EntradaLista=1 again the next cycle.
2. Stream 1,1,1,0,0,0,0,0 with SalidaLista=0 for 5 cycles, EntradaValida=1 with Entrada=1 throughout -> Salida=1 and SalidaValida=1 stable all 5 cycles; EntradaLista=0; P and Contador=8 unchanged; parity is released on the first cycle SalidaLista=1.
3. Same frame as case 1 with EntradaValida low on alternate cycles -> Contador advances only on valid cycles; final Salida=0 after 16 cycles.
4. Abort 5 bits (1,1,0,1,1) into a frame; pulse Abortar together with EntradaValida=1 -> next cycle Contador=0, Ocupado=0, that bit is dropped; a fresh 8-bit all-ones frame then gives Salida=0.
5. Assert Reset asynchronously (between clock edges) in ENTREGA -> SalidaValida, Salida, Contador and Ocupado go to 0 before the next edge; after release, a new frame runs normally.
6. PARIDAD_IMPAR=1, ANCHO_TRAMA=1; send bit 0 then bit 1 back-to-back with SalidaLista=1 -> Salida=1 then Salida=0, each frame taking 2 cycles.

Source files
------------

// File: rtl/acumulador_paridad_serie.sv
// Serial parity accumulator.
// Folds each accepted bit into a running parity register by XOR-ing the pair
// {parity, incoming bit}. After ANCHO_TRAMA accepted bits it holds the frame
// parity on a valid/ready output until the consumer takes it.
module acumulador_paridad_serie #(
  parameter int unsigned ANCHO_TRAMA   = 8,
  parameter int unsigned PARIDAD_IMPAR = 0
) (
  input  logic                               Reloj,
  input  logic                               Reset,
  input  logic                               Entrada,
  input  logic                               EntradaValida,
  output logic                               EntradaLista,
  input  logic                               Abortar,
  output logic                               Salida,
  output logic                               SalidaValida,
  input  logic                               SalidaLista,
  output logic [$clog2(ANCHO_TRAMA+1)-1:0]   Contador,
  output logic                               Ocupado
);

  localparam int unsigned CW = $clog2(ANCHO_TRAMA + 1);

  // The bit count that closes a frame, sized to the counter.
  localparam logic [CW-1:0] ULTIMO = CW'(ANCHO_TRAMA);

  // Odd parity is the even parity inverted once at the output.
  localparam logic IMPAR = (PARIDAD_IMPAR != 0);

  localparam logic [1:0] REPOSO  = 2'd0;
  localparam logic [1:0] ACUMULA = 2'd1;
  localparam logic [1:0] ENTREGA = 2'd2;

  logic [1:0]    estado;
  logic          paridad;
  logic [CW-1:0] cuenta;
  logic          acepta;
  logic [CW-1:0] cuenta_sig;
  logic          paridad_sig;

  // Input handshake and the next count/parity for an accepted bit.
  always_comb begin
    acepta      = EntradaValida && EntradaLista;
    cuenta_sig  = cuenta + CW'(1);
    paridad_sig = ^{paridad, Entrada};
  end

  // State, parity and bit count; abort outranks both handshakes.
  always_ff @(posedge Reloj or posedge Reset) begin
    if (Reset) begin
      estado  <= REPOSO;
      paridad <= 1'b0;
      cuenta  <= '0;
    end else if (Abortar) begin
      estado  <= REPOSO;
      paridad <= 1'b0;
      cuenta  <= '0;
    end else begin
      case (estado)
        REPOSO: begin
          if (acepta) begin
            paridad <= Entrada;
            cuenta  <= CW'(1);
            estado  <= (ANCHO_TRAMA == 1) ? ENTREGA : ACUMULA;
          end
        end
        ACUMULA: begin
          if (acepta) begin
            paridad <= paridad_sig;
            cuenta  <= cuenta_sig;
            if (cuenta_sig == ULTIMO) begin
              estado <= ENTREGA;
            end
          end
        end
        ENTREGA: begin
          if (SalidaLista) begin
            estado  <= REPOSO;
            paridad <= 1'b0;
            cuenta  <= '0;
          end
        end
        default: begin
          estado  <= REPOSO;
          paridad <= 1'b0;
          cuenta  <= '0;
        end
      endcase
    end
  end

  // Outputs decoded from state; ready drops immediately while reset is held.
  always_comb begin
    EntradaLista = !Reset && (estado != ENTREGA);
    SalidaValida = (estado == ENTREGA);
    Salida       = SalidaValida && (paridad ^ IMPAR);
    Ocupado      = (estado != REPOSO);
    Contador     = cuenta;
  end

endmodule

// File: tb/tb_acumulador_paridad_serie.sv
// Testbench for acumulador_paridad_serie: one 8-bit even-parity instance and
// one 1-bit odd-parity instance, checked against a frame-level model.
module tb_acumulador_paridad_serie;

  logic       clk = 1'b0;
  logic       rst;
  logic       ent [2];
  logic       ev  [2];
  logic       ab  [2];
  logic       sl  [2];
  logic       el  [2];
  logic       sal [2];
  logic       sv  [2];
  logic       ocu [2];
  logic [3:0] cnt0;
  logic [0:0] cnt1;

  int tests    = 0;
  int failures = 0;

  // Frame-level reference: bits taken, ones seen, and whether a result waits.
  int m_cnt   [2];
  int m_ones  [2];
  bit m_deliv [2];
  int width   [2] = '{8, 1};
  int odd     [2] = '{0, 1};

  always #5 clk = ~clk;

  acumulador_paridad_serie #(.ANCHO_TRAMA(8), .PARIDAD_IMPAR(0)) dut0 (
    .Reloj(clk), .Reset(rst), .Entrada(ent[0]), .EntradaValida(ev[0]),
    .EntradaLista(el[0]), .Abortar(ab[0]), .Salida(sal[0]),
    .SalidaValida(sv[0]), .SalidaLista(sl[0]), .Contador(cnt0), .Ocupado(ocu[0])
  );

  acumulador_paridad_serie #(.ANCHO_TRAMA(1), .PARIDAD_IMPAR(1)) dut1 (
    .Reloj(clk), .Reset(rst), .Entrada(ent[1]), .EntradaValida(ev[1]),
    .EntradaLista(el[1]), .Abortar(ab[1]), .Salida(sal[1]),
    .SalidaValida(sv[1]), .SalidaLista(sl[1]), .Contador(cnt1), .Ocupado(ocu[1])
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d]   = 0;
      m_ones[d]  = 0;
      m_deliv[d] = 1'b0;
    end
  endtask

  // What one rising edge does to a frame, given the inputs held across it.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (ab[d]) begin
        m_cnt[d] = 0; m_ones[d] = 0; m_deliv[d] = 1'b0;
      end else if (m_deliv[d]) begin
        if (sl[d]) begin
          m_cnt[d] = 0; m_ones[d] = 0; m_deliv[d] = 1'b0;
        end
      end else if (ev[d]) begin
        m_cnt[d]++;
        m_ones[d] += int'(ent[d]);
        if (m_cnt[d] == width[d]) m_deliv[d] = 1'b1;
      end
    end
  endtask

  task automatic check_output();
    logic [7:0] cnt_obs;
    for (int d = 0; d < 2; d++) begin
      cnt_obs = (d == 0) ? 8'(cnt0) : 8'(cnt1);
      check($sformatf("d%0d lista", d),    8'(el[d]),  8'(!rst && !m_deliv[d]));
      check($sformatf("d%0d valida", d),   8'(sv[d]),  8'(m_deliv[d]));
      check($sformatf("d%0d salida", d),   8'(sal[d]),
            m_deliv[d] ? 8'((m_ones[d] % 2) ^ odd[d]) : 8'd0);
      check($sformatf("d%0d ocupado", d),  8'(ocu[d]), 8'(m_deliv[d] || (m_cnt[d] != 0)));
      check($sformatf("d%0d contador", d), cnt_obs,    8'(m_cnt[d]));
    end
  endtask

  // Drive one instance for one cycle (the other idles), then check both.
  task automatic apply_stimulus(input int d, input bit v, input bit b, input bit a, input bit r);
    for (int k = 0; k < 2; k++) begin
      ev[k] = 1'b0; ab[k] = 1'b0; sl[k] = 1'b0;
    end
    ev[d] = v; ent[d] = b; ab[d] = a; sl[d] = r;
    @(posedge clk);
    model_edge();
    #1;
    check_output();
  endtask

  task automatic send_frame(input int d, input logic [7:0] bits, input bit r);
    for (int i = 0; i < width[d]; i++) apply_stimulus(d, 1'b1, bits[7 - i], 1'b0, r);
  endtask

  initial begin
    logic [7:0] f1;
    f1 = 8'b1011_0010;
    for (int d = 0; d < 2; d++) begin
      ent[d] = 1'b0; ev[d] = 1'b0; ab[d] = 1'b0; sl[d] = 1'b0;
    end
    rst = 1'b1;
    model_reset();
    #1;
    check_output();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_output();

    // Case 1: back-to-back frame, consumer always ready.
    send_frame(0, f1, 1'b1);
    check("t1 valida", 8'(sv[0]), 8'd1);
    check("t1 salida", 8'(sal[0]), 8'd0);
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t1 lista", 8'(el[0]), 8'd1);

    // Case 2: result held while consumer stalls with input pending.
    send_frame(0, 8'b1110_0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(0, 1'b1, 1'b1, 1'b0, 1'b0);
      check("t2 salida", 8'(sal[0]), 8'd1);
      check("t2 contador", 8'(cnt0), 8'd8);
    end
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Case 3: valid on alternate cycles.
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) apply_stimulus(0, 1'b1, f1[7 - i / 2], 1'b0, 1'b1);
      else            apply_stimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Case 4: abort mid-frame together with a valid bit, then all-ones frame.
    send_frame(0, 8'b1101_1000, 1'b1);
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) apply_stimulus(0, 1'b1, (i == 2) ? 1'b0 : 1'b1, 1'b0, 1'b0);
    apply_stimulus(0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t4 contador", 8'(cnt0), 8'd0);
    check("t4 ocupado", 8'(ocu[0]), 8'd0);
    send_frame(0, 8'hFF, 1'b0);
    check("t4 salida", 8'(sal[0]), 8'd0);

    // Case 5: asynchronous reset while a result is waiting.
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_output();
    #2;
    rst = 1'b0;
    #1;
    check_output();
    send_frame(0, 8'b0100_0000, 1'b1);
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Case 6: single-bit odd-parity frames back-to-back.
    apply_stimulus(1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t6 salida a", 8'(sal[1]), 8'd1);
    apply_stimulus(1, 1'b1, 1'b1, 1'b0, 1'b1);
    apply_stimulus(1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("t6 salida b", 8'(sal[1]), 8'd0);
    apply_stimulus(1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(i % 2, ($urandom_range(3) != 0), 1'($urandom),
                     ($urandom_range(15) == 0), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
